// File: rtl/game_evt_pkg.sv
// Shared encodings for the game event arbiter: game phases and event source IDs.
package game_evt_pkg;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_RUNNING = 2'd1,
    PH_DRAIN   = 2'd2,
    PH_OVER    = 2'd3
  } phase_e;

  localparam logic EVT_SCORE = 1'b0;
  localparam logic EVT_TICK  = 1'b1;

endpackage

// File: rtl/game_event_arbiter_pend_counter.sv
// Saturating pending-event counter: counts gated pulses up, acks down,
// and flags a pulse that is lost because the count is already at max.
module pend_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         sat_drop_o
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         inc_eff, dec_eff;

  always_comb begin
    inc_eff    = en_i & inc_i;
    dec_eff    = dec_i & (cnt_q != '0);
    sat_drop_o = inc_eff & ~dec_eff & (cnt_q == MAX);
    cnt_d      = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_eff && !dec_eff && cnt_q != MAX) begin
      cnt_d = cnt_q + ONE;
    end else if (dec_eff && !inc_eff) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/game_event_arbiter.sv
// Game event arbiter: phase FSM, pending-event capture and one-at-a-time
// valid/ack presentation. ARB_FIXED_PRIO_EN selects score-over-tick priority.
module game_event_arbiter
  import game_evt_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int DROP_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              increment_score_pe,
  input  logic              game_clock_pe,
  input  logic              start_pe,
  input  logic              time_zero,
  output logic              evt_valid,
  output logic              evt_id,
  input  logic              evt_ack,
  output logic [CNT_W-1:0]  pend_score,
  output logic [CNT_W-1:0]  pend_tick,
  output logic [DROP_W-1:0] drop_count,
  output logic [1:0]        phase,
  output logic              game_over
);

  phase_e            phase_q, phase_d;
  logic              valid_q, valid_d;
  logic              id_q, id_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              clr, cap_en, ack_fire;
  logic              drop_s, drop_t;
  logic              has_s, has_t, sel_id;
  logic [1:0]        n_drops;
  logic [DROP_W:0]   drop_sum;

  assign ack_fire = valid_q & evt_ack;
  assign cap_en   = (phase_q == PH_RUNNING);
  assign clr      = start_pe & ((phase_q == PH_IDLE) | (phase_q == PH_OVER));

  pend_counter #(.W(CNT_W)) u_score (
    .clock      (clock),
    .reset      (reset),
    .clr_i      (clr),
    .en_i       (cap_en),
    .inc_i      (increment_score_pe),
    .dec_i      (ack_fire & (id_q == EVT_SCORE)),
    .count_o    (pend_score),
    .sat_drop_o (drop_s)
  );

  pend_counter #(.W(CNT_W)) u_tick (
    .clock      (clock),
    .reset      (reset),
    .clr_i      (clr),
    .en_i       (cap_en),
    .inc_i      (game_clock_pe),
    .dec_i      (ack_fire & (id_q == EVT_TICK)),
    .count_o    (pend_tick),
    .sat_drop_o (drop_t)
  );

  assign has_s = (pend_score != '0);
  assign has_t = (pend_tick != '0);

`ifdef ARB_FIXED_PRIO_EN
  assign sel_id = has_s ? EVT_SCORE : EVT_TICK;
`else
  // ptr_q names the source that wins the next tie; it flips away from each acked source
  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (ack_fire) ptr_d = ~id_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ptr_q <= EVT_SCORE;
    else        ptr_q <= ptr_d;
  end

  assign sel_id = (has_s & has_t) ? ptr_q : (has_s ? EVT_SCORE : EVT_TICK);
`endif

  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      PH_IDLE:    if (start_pe) phase_d = PH_RUNNING;
      PH_RUNNING: if (time_zero) phase_d = PH_DRAIN;
      PH_DRAIN:   if (!has_s && !has_t && !valid_q) phase_d = PH_OVER;
      PH_OVER:    if (start_pe) phase_d = PH_RUNNING;
      default:    phase_d = PH_IDLE;
    endcase
  end

  // An ack always forces one empty cycle before the next event is offered
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    if (ack_fire) begin
      valid_d = 1'b0;
    end else if (!valid_q && (has_s || has_t)) begin
      valid_d = 1'b1;
      id_d    = sel_id;
    end
  end

  always_comb begin
    n_drops  = {1'b0, drop_s} + {1'b0, drop_t};
    drop_sum = {1'b0, drop_q} + {{(DROP_W-1){1'b0}}, n_drops};
    if (clr)                 drop_d = '0;
    else if (drop_sum[DROP_W]) drop_d = '1;
    else                     drop_d = drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_IDLE;
      valid_q <= 1'b0;
      id_q    <= EVT_SCORE;
      drop_q  <= '0;
    end else begin
      phase_q <= phase_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      drop_q  <= drop_d;
    end
  end

  assign evt_valid  = valid_q;
  assign evt_id     = id_q;
  assign drop_count = drop_q;
  assign phase      = phase_q;
  assign game_over  = (phase_q == PH_OVER);

endmodule

// File: tb/tb_game_event_arbiter.sv
// Directed self-checking bench for game_event_arbiter; honours ARB_FIXED_PRIO_EN.
module tb_game_event_arbiter;

  logic       clock;
  logic       reset;
  logic       increment_score_pe;
  logic       game_clock_pe;
  logic       start_pe;
  logic       time_zero;
  logic       evt_valid;
  logic       evt_id;
  logic       evt_ack;
  logic [3:0] pend_score;
  logic [3:0] pend_tick;
  logic [7:0] drop_count;
  logic [1:0] phase;
  logic       game_over;

  int total = 0;
  int bad   = 0;

  game_event_arbiter #(.CNT_W(4), .DROP_W(8)) dut (
    .clock              (clock),
    .reset              (reset),
    .increment_score_pe (increment_score_pe),
    .game_clock_pe      (game_clock_pe),
    .start_pe           (start_pe),
    .time_zero          (time_zero),
    .evt_valid          (evt_valid),
    .evt_id             (evt_id),
    .evt_ack            (evt_ack),
    .pend_score         (pend_score),
    .pend_tick          (pend_tick),
    .drop_count         (drop_count),
    .phase              (phase),
    .game_over          (game_over)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset_start();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
    start_pe = 1'b1;
    tick();
    start_pe = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (phase !== 2'd0) begin bad++; $display("FAIL reset_phase: got %0d want 0", phase); end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", evt_valid); end
    reset = 1'b1;
    tick();
    start_pe = 1'b1;
    tick();
    start_pe = 1'b0;
    increment_score_pe = 1'b1;
    repeat (3) tick();
    increment_score_pe = 1'b0;
    total++; if (pend_score !== 4'd3) begin bad++; $display("FAIL midrun_pend: got %0d want 3", pend_score); end
    #2 reset = 1'b0;
    #1;
    total++; if (pend_score !== 4'd0 || evt_valid !== 1'b0 || drop_count !== 8'd0 || phase !== 2'd0)
      begin bad++; $display("FAIL async_reset: pend=%0d valid=%0b drop=%0d phase=%0d want all 0", pend_score, evt_valid, drop_count, phase); end
    #1 reset = 1'b1;
    repeat (3) tick();
    total++; if (evt_valid !== 1'b0 || phase !== 2'd0)
      begin bad++; $display("FAIL post_reset: valid=%0b phase=%0d want 0/0", evt_valid, phase); end
  endtask

  task automatic test_single();
    do_reset_start();
    total++; if (phase !== 2'd1) begin bad++; $display("FAIL start_phase: got %0d want 1", phase); end
    increment_score_pe = 1'b1;
    tick();
    increment_score_pe = 1'b0;
    total++; if (pend_score !== 4'd1 || evt_valid !== 1'b0)
      begin bad++; $display("FAIL single_k: pend=%0d valid=%0b want 1/0", pend_score, evt_valid); end
    tick();
    total++; if (evt_valid !== 1'b1 || evt_id !== 1'b0)
      begin bad++; $display("FAIL single_k1: valid=%0b id=%0b want 1/0", evt_valid, evt_id); end
    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
    total++; if (pend_score !== 4'd0 || evt_valid !== 1'b0)
      begin bad++; $display("FAIL single_ack: pend=%0d valid=%0b want 0/0", pend_score, evt_valid); end
  endtask

  task automatic test_arbitration();
    logic exp_id [6];
    int   got;
`ifdef ARB_FIXED_PRIO_EN
    exp_id = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    do_reset_start();
    increment_score_pe = 1'b1;
    game_clock_pe      = 1'b1;
    repeat (3) tick();
    increment_score_pe = 1'b0;
    game_clock_pe      = 1'b0;
    total++; if (pend_score !== 4'd3 || pend_tick !== 4'd3)
      begin bad++; $display("FAIL both_pend: score=%0d tick=%0d want 3/3", pend_score, pend_tick); end
    got = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      if (evt_valid) begin
        total++; if (evt_id !== exp_id[got])
          begin bad++; $display("FAIL arb_seq[%0d]: got %0b want %0b", got, evt_id, exp_id[got]); end
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        total++; if (evt_valid !== 1'b0)
          begin bad++; $display("FAIL arb_gap[%0d]: valid=%0b want 0", got, evt_valid); end
        got++;
      end else begin
        tick();
      end
    end
    total++; if (got !== 6) begin bad++; $display("FAIL arb_count: got %0d events want 6", got); end
    total++; if (pend_score !== 4'd0 || pend_tick !== 4'd0)
      begin bad++; $display("FAIL arb_empty: score=%0d tick=%0d want 0/0", pend_score, pend_tick); end
  endtask

  task automatic test_saturation();
    do_reset_start();
    increment_score_pe = 1'b1;
    repeat (17) tick();
    increment_score_pe = 1'b0;
    total++; if (pend_score !== 4'd15 || drop_count !== 8'd2)
      begin bad++; $display("FAIL sat_score: pend=%0d drop=%0d want 15/2", pend_score, drop_count); end
    game_clock_pe = 1'b1;
    repeat (15) tick();
    increment_score_pe = 1'b1;
    tick();
    increment_score_pe = 1'b0;
    game_clock_pe      = 1'b0;
    total++; if (pend_tick !== 4'd15 || pend_score !== 4'd15 || drop_count !== 8'd4)
      begin bad++; $display("FAIL sat_both: tick=%0d score=%0d drop=%0d want 15/15/4", pend_tick, pend_score, drop_count); end
  endtask

  task automatic test_back_to_back();
    do_reset_start();
    increment_score_pe = 1'b1;
    repeat (2) tick();
    increment_score_pe = 1'b0;
    total++; if (pend_score !== 4'd2 || evt_valid !== 1'b1 || evt_id !== 1'b0)
      begin bad++; $display("FAIL b2b_setup: pend=%0d valid=%0b id=%0b want 2/1/0", pend_score, evt_valid, evt_id); end
    increment_score_pe = 1'b1;
    evt_ack            = 1'b1;
    tick();
    increment_score_pe = 1'b0;
    evt_ack            = 1'b0;
    total++; if (pend_score !== 4'd2 || evt_valid !== 1'b0)
      begin bad++; $display("FAIL pulse_ack_same: pend=%0d valid=%0b want 2/0", pend_score, evt_valid); end
  endtask

  task automatic test_drain();
    int acks;
    int waited;
    do_reset_start();
    game_clock_pe = 1'b1;
    repeat (2) tick();
    game_clock_pe = 1'b0;
    time_zero = 1'b1;
    tick();
    time_zero = 1'b0;
    total++; if (phase !== 2'd2 || pend_tick !== 4'd2)
      begin bad++; $display("FAIL drain_enter: phase=%0d tick=%0d want 2/2", phase, pend_tick); end
    start_pe           = 1'b1;
    increment_score_pe = 1'b1;
    tick();
    start_pe           = 1'b0;
    increment_score_pe = 1'b0;
    total++; if (phase !== 2'd2 || pend_score !== 4'd0 || pend_tick !== 4'd2)
      begin bad++; $display("FAIL drain_ignore: phase=%0d score=%0d tick=%0d want 2/0/2", phase, pend_score, pend_tick); end
    acks = 0;
    for (int c = 0; c < 20 && acks < 2; c++) begin
      if (evt_valid) begin
        total++; if (evt_id !== 1'b1) begin bad++; $display("FAIL drain_id: got %0b want 1", evt_id); end
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        acks++;
      end else begin
        tick();
      end
    end
    total++; if (acks !== 2) begin bad++; $display("FAIL drain_acks: got %0d want 2", acks); end
    waited = 0;
    while (!game_over && waited < 5) begin
      tick();
      waited++;
    end
    total++; if (phase !== 2'd3 || game_over !== 1'b1)
      begin bad++; $display("FAIL over: phase=%0d game_over=%0b want 3/1", phase, game_over); end
    start_pe = 1'b1;
    tick();
    start_pe = 1'b0;
    total++; if (phase !== 2'd1 || game_over !== 1'b0 || pend_score !== 4'd0 || pend_tick !== 4'd0 || drop_count !== 8'd0)
      begin bad++; $display("FAIL restart: phase=%0d over=%0b score=%0d tick=%0d drop=%0d want 1/0/0/0/0", phase, game_over, pend_score, pend_tick, drop_count); end
  endtask

  initial begin
    reset              = 1'b0;
    increment_score_pe = 1'b0;
    game_clock_pe      = 1'b0;
    start_pe           = 1'b0;
    time_zero          = 1'b0;
    evt_ack            = 1'b0;
    #12;
    test_reset();
    test_single();
    test_arbitration();
    test_saturation();
    test_back_to_back();
    test_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
